count_leading_zeros64: RTL and testbench
========================================

Name: count_leading_zeros64

Overview:
Registered 64-bit count-leading-zeros (CLZ) unit for arithmetic datapaths such as normalisation shifters and priority logic. It samples a 64-bit word with a valid qualifier and, one clock later, presents the number of consecutive zero bits starting at the MSB (bit 63). It also presents an all-zero flag. The block is purely feed-forward: no backpressure and no internal state beyond the output register stage.

Parameters:
none (width fixed at 64; count width fixed at 7 bits)

Ports:
i_CLK  input  1  system clock; all state updates on rising edge
i_RST  input  1  synchronous, active-high reset
i_VALID  input  1  qualifies i_WORD for sampling this cycle
i_WORD  input  64  operand; bit 63 is the MSB, where counting starts
o_VALID  output  1  o_COUNT/o_ZERO hold the result for the word sampled on the previous edge
o_COUNT  output  7  leading-zero count, range 0..64
o_ZERO  output  1  1 when the sampled word was all zeros (o_COUNT = 64)

Behaviour:
- Reset: when i_RST = 1 at a rising edge, o_VALID, o_COUNT and o_ZERO all become 0. Reset takes priority over i_VALID on the same edge.
- Latency: exactly 1 cycle. If i_VALID = 1 at edge N, the result for i_WORD sampled at edge N is visible after edge N, and o_VALID = 1 until the next edge.
- o_VALID <= i_VALID on every non-reset edge.
- If i_VALID = 0: o_VALID goes to 0, and o_COUNT/o_ZERO hold their previous values (no toggling on idle cycles).
- Count definition: o_COUNT = 63 - (index of the highest set bit of i_WORD). If i_WORD = 0, o_COUNT = 64 (binary 1000000).
- o_ZERO = 1 if and only if o_COUNT = 64.
- o_COUNT[6] is set only for the all-zero case, so o_COUNT[6] equals o_ZERO.
- Implementation structure, required for timing:
  - log-depth tree: 16 nibble CLZ encoders (2-bit count plus nibble-zero flag);
  - merged pairwise into 8-bit, 16-bit, 32-bit and 64-bit levels;
  - at each merge: if the upper half is all zero, result = {1, lower count}, else {0, upper count}; zero flag = AND of both halves' zero flags.
  - Combinational tree feeds the output register; no combinational path from i_WORD to any output.
- Back-to-back valid words on consecutive cycles are each processed (throughput 1 word per cycle).
- Reset asserted mid-stream discards the in-flight result. The first valid output after reset release corresponds to the first word sampled with i_VALID = 1 while i_RST = 0.
- X/undefined inputs while i_VALID = 0 must not affect the outputs.

Test Plan:
1. Reset: hold i_RST = 1 for 2 cycles with i_VALID = 1 and i_WORD = 0 -> o_VALID = 0, o_COUNT = 0, o_ZERO = 0. Release reset with i_VALID = 1 and i_WORD = 0 -> next cycle o_VALID = 1, o_COUNT = 64, o_ZERO = 1.
2. Mixed-bit word: i_WORD = 0x0000_A401_0000_0001 with i_VALID = 1 -> next cycle o_COUNT = 16, o_ZERO = 0, o_VALID = 1.
3. Extremes: 0x8000_0000_0000_0000 -> 0; 0xFFFF_FFFF_FFFF_FFFF -> 0; 0x0000_0000_0000_0001 -> 63; each o_ZERO = 0.
4. Walking one: i_WORD = 1<<k for k = 63 down to 0 on consecutive cycles -> o_COUNT = 63-k each cycle, 1-cycle delayed, o_VALID continuously 1. Repeat with random lower bits below bit k, same counts.
5. Idle hold: valid word 0x0000_0001_0000_0000 (count 31), then i_VALID = 0 with i_WORD changing randomly -> o_VALID = 0, o_COUNT stays 31.
6. Random regression: 10k random words, including sparse words with random leading-zero lengths 0..64 -> o_COUNT matches reference model, o_ZERO = (o_COUNT == 64). Assert i_RST mid-stream -> outputs clear on the next edge.

Source files
------------

// File: rtl/count_leading_zeros64.sv
// Registered 64-bit count-leading-zeros unit.
// Nibble encoders feed a log-depth merge tree ahead of one output register.
module count_leading_zeros64 (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_VALID,
  input  logic [63:0] i_WORD,
  output logic        o_VALID,
  output logic [6:0]  o_COUNT,
  output logic        o_ZERO
);

  logic [1:0] w_c4  [16];
  logic       w_z4  [16];
  logic [2:0] w_c8  [8];
  logic       w_z8  [8];
  logic [3:0] w_c16 [4];
  logic       w_z16 [4];
  logic [4:0] w_c32 [2];
  logic       w_z32 [2];
  logic [5:0] w_c64;
  logic       w_z64;
  logic [6:0] w_count;

  logic       r_valid;
  logic [6:0] r_count;
  logic       r_zero;

  // Nibble i covers bits 4i+3..4i; an all-zero nibble reports count 3.
  for (genvar i = 0; i < 16; i++) begin : g_l4
    logic [3:0] w_n;
    assign w_n      = i_WORD[4*i +: 4];
    assign w_z4[i]  = ~|w_n;
    assign w_c4[i]  = {~w_n[3] & ~w_n[2],
                       ~w_n[3] & (w_n[2] | ~w_n[1])};
  end

  for (genvar i = 0; i < 8; i++) begin : g_l8
    assign w_z8[i] = w_z4[2*i+1] & w_z4[2*i];
    assign w_c8[i] = w_z4[2*i+1] ? {1'b1, w_c4[2*i]}
                                 : {1'b0, w_c4[2*i+1]};
  end

  for (genvar i = 0; i < 4; i++) begin : g_l16
    assign w_z16[i] = w_z8[2*i+1] & w_z8[2*i];
    assign w_c16[i] = w_z8[2*i+1] ? {1'b1, w_c8[2*i]}
                                  : {1'b0, w_c8[2*i+1]};
  end

  for (genvar i = 0; i < 2; i++) begin : g_l32
    assign w_z32[i] = w_z16[2*i+1] & w_z16[2*i];
    assign w_c32[i] = w_z16[2*i+1] ? {1'b1, w_c16[2*i]}
                                   : {1'b0, w_c16[2*i+1]};
  end

  assign w_z64 = w_z32[1] & w_z32[0];
  assign w_c64 = w_z32[1] ? {1'b1, w_c32[0]}
                          : {1'b0, w_c32[1]};

  // The tree saturates at 63 for an all-zero word; remap that to 64.
  assign w_count = {w_z64, w_z64 ? 6'd0 : w_c64};

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_valid <= 1'b0;
      r_count <= 7'd0;
      r_zero  <= 1'b0;
    end else begin
      r_valid <= i_VALID;
      if (i_VALID) begin
        r_count <= w_count;
        r_zero  <= w_z64;
      end
    end
  end

  assign o_VALID = r_valid;
  assign o_COUNT = r_count;
  assign o_ZERO  = r_zero;

endmodule

// File: tb/tb_count_leading_zeros64.sv
// Directed and randomized bench for count_leading_zeros64.
// Expected results come from a bit-scan reference model.
module tb_count_leading_zeros64;

  logic        clk;
  logic        rst;
  logic        vin;
  logic [63:0] word;
  logic        vout;
  logic [6:0]  cnt;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  logic       exp_valid;
  logic [6:0] exp_cnt;
  logic       exp_zero;

  count_leading_zeros64 dut (
    .i_CLK   (clk),
    .i_RST   (rst),
    .i_VALID (vin),
    .i_WORD  (word),
    .o_VALID (vout),
    .o_COUNT (cnt),
    .o_ZERO  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_clz(input logic [63:0] w);
    for (int i = 63; i >= 0; i--)
      if (w[i]) return 63 - i;
    return 64;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [63:0] w, input string tag);
    rst  = r;
    vin  = v;
    word = w;
    @(posedge clk);
    #1;
    if (r) begin
      exp_valid = 1'b0;
      exp_cnt   = 7'd0;
      exp_zero  = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        exp_cnt  = 7'(ref_clz(w));
        exp_zero = (ref_clz(w) == 64);
      end
    end
    chk({tag, ".valid"}, int'(vout), int'(exp_valid));
    chk({tag, ".count"}, int'(cnt),  int'(exp_cnt));
    chk({tag, ".zero"},  int'(zero), int'(exp_zero));
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] w;
    int lz;
    rst = 1'b1; vin = 1'b1; word = 64'd0;
    exp_valid = 1'b0; exp_cnt = 7'd0; exp_zero = 1'b0;

    step(1'b1, 1'b1, 64'd0, "reset0");
    step(1'b1, 1'b1, 64'd0, "reset1");
    step(1'b0, 1'b1, 64'd0, "allzero");
    chk("allzero.abs", int'(cnt), 64);

    step(1'b0, 1'b1, 64'h0000_A401_0000_0001, "mixed");
    chk("mixed.abs", int'(cnt), 16);

    step(1'b0, 1'b1, 64'h8000_0000_0000_0000, "msb");
    chk("msb.abs", int'(cnt), 0);
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "ones");
    chk("ones.abs", int'(cnt), 0);
    step(1'b0, 1'b1, 64'h0000_0000_0000_0001, "lsb");
    chk("lsb.abs", int'(cnt), 63);

    for (int k = 63; k >= 0; k--)
      step(1'b0, 1'b1, 64'd1 << k, "walk");
    for (int k = 63; k >= 0; k--) begin
      w = (64'd1 << k) | (rnd64() & ((64'd1 << k) - 64'd1));
      step(1'b0, 1'b1, w, "walkrnd");
    end

    step(1'b0, 1'b1, 64'h0000_0001_0000_0000, "holdset");
    chk("holdset.abs", int'(cnt), 31);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b0, rnd64(), "idle");
    chk("idle.abs", int'(cnt), 31);
    step(1'b0, 1'b0, 'x, "idlex");
    chk("idlex.abs", int'(cnt), 31);

    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        step(1'b1, 1'b1, rnd64(), "midreset");
        continue;
      end
      if ($urandom_range(0, 1) == 0) begin
        lz = $urandom_range(0, 64);
        w = rnd64();
        w[63] = 1'b1;
        w = w >> lz;
      end else begin
        w = rnd64();
      end
      step(1'b0, ($urandom_range(0, 7) != 0), w, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
